butterfly_r2_shared: RTL

Radix-2 complex butterfly that shares two multipliers over two clock phases. It runs in either DIT or DIF mode, which is selected per operation. Other per-operation options are twiddle conjugation (inverse FFT) and a divide-by-2 stage scaling. It has a valid/ready handshake on both sides, so FFT stage controllers can stream butterflies at one per two cycles and stall on downstream backpressure.

---
 rtl/butterfly_r2_shared.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/butterfly_r2_shared.sv
// butterfly_r2_shared: radix-2 complex butterfly (DIT or DIF, chosen per operation)
// that shares two multipliers across two clock phases. The twiddle can be conjugated
// for the inverse FFT, and both outputs can be halved. Valid/ready handshake on both
// sides gives one butterfly per two cycles and stalls on downstream backpressure.
// Optional build macro: BFLY_ROUND_EN
//   defined     -> product reduction rounds half up
//   not defined -> product reduction truncates (floor)
module butterfly_r2_shared #(
    parameter int DATA_WIDTH   = 32,
    parameter int FACTOR_WIDTH = 16,
    parameter int FRAC_BITS    = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*DATA_WIDTH-1:0]   in_x0,
    input  logic [2*DATA_WIDTH-1:0]   in_x1,
    input  logic [2*FACTOR_WIDTH-1:0] in_w,
    input  logic                      in_mode,
    input  logic                      in_inv,
    input  logic                      in_scale,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_x0,
    output logic [2*DATA_WIDTH-1:0]   out_x1
);

    localparam int DW = DATA_WIDTH;
    localparam int FW = FACTOR_WIDTH;
    localparam int PW = DATA_WIDTH + FACTOR_WIDTH;

`ifdef BFLY_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_BITS - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PH0,
        S_PH1
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic signed [DW-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic signed [FW-1:0] w_re_q, w_re_d, w_im_q, w_im_d;
    logic signed [DW-1:0] pr_q, pr_d, pi_q, pi_d;
    logic                 mode_q, mode_d, scale_q, scale_d;
    logic [2*DW-1:0]      out_x0_q, out_x0_d, out_x1_q, out_x1_d;
    logic                 out_valid_q, out_valid_d;

    logic load_ok;
    logic accept;
    logic out_load;

    // Handshake and phase sequencing
    always_comb begin
        state_d  = state_q;
        load_ok  = !out_valid_q || out_ready;
        in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_PH1) && load_ok));
        accept   = in_valid && in_ready;
        out_load = (state_q == S_PH1) && load_ok;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PH0;
            S_PH0:  state_d = S_PH1;
            S_PH1: begin
                if (load_ok) state_d = accept ? S_PH0 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic signed [DW-1:0] x0_re, x0_im, x1_re, x1_im;
    logic signed [FW-1:0] w_re_in, w_im_raw, w_im_in;
    logic signed [DW-1:0] m_a;
    logic signed [FW-1:0] m1_b, m2_b;
    logic signed [PW-1:0] prod1, prod2;
    logic signed [DW-1:0] red1, red2;
    logic signed [DW-1:0] p_re, p_im;
    logic signed [DW-1:0] o0_re, o0_im, o1_re, o1_im;

    // Shared multipliers: PH0 forms a_re*w_re / a_re*w_im, PH1 forms a_im*w_im / a_im*w_re
    always_comb begin
        m_a   = (state_q == S_PH1) ? a_im_q : a_re_q;
        m1_b  = (state_q == S_PH1) ? w_im_q : w_re_q;
        m2_b  = (state_q == S_PH1) ? w_re_q : w_im_q;
        prod1 = PW'(m_a) * PW'(m1_b);
        prod2 = PW'(m_a) * PW'(m2_b);
        red1  = DW'((prod1 + RND) >>> FRAC_BITS);
        red2  = DW'((prod2 + RND) >>> FRAC_BITS);
    end

    // Operand capture, partial-product register and output register next state
    always_comb begin
        x0_re    = $signed(in_x0[2*DW-1:DW]);
        x0_im    = $signed(in_x0[DW-1:0]);
        x1_re    = $signed(in_x1[2*DW-1:DW]);
        x1_im    = $signed(in_x1[DW-1:0]);
        w_re_in  = $signed(in_w[2*FW-1:FW]);
        w_im_raw = $signed(in_w[FW-1:0]);
        w_im_in  = in_inv ? -w_im_raw : w_im_raw;

        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        b_re_d  = b_re_q;
        b_im_d  = b_im_q;
        w_re_d  = w_re_q;
        w_im_d  = w_im_q;
        mode_d  = mode_q;
        scale_d = scale_q;
        pr_d    = pr_q;
        pi_d    = pi_q;

        if (accept) begin
            if (in_mode) begin
                a_re_d = x0_re - x1_re;
                a_im_d = x0_im - x1_im;
                b_re_d = x0_re + x1_re;
                b_im_d = x0_im + x1_im;
            end else begin
                a_re_d = x1_re;
                a_im_d = x1_im;
                b_re_d = x0_re;
                b_im_d = x0_im;
            end
            w_re_d  = w_re_in;
            w_im_d  = w_im_in;
            mode_d  = in_mode;
            scale_d = in_scale;
        end

        if (state_q == S_PH0) begin
            pr_d = red1;
            pi_d = red2;
        end

        // Complex product completes combinationally during PH1
        p_re = pr_q - red1;
        p_im = pi_q + red2;

        if (mode_q) begin
            o0_re = b_re_q;
            o0_im = b_im_q;
            o1_re = p_re;
            o1_im = p_im;
        end else begin
            o0_re = b_re_q + p_re;
            o0_im = b_im_q + p_im;
            o1_re = b_re_q - p_re;
            o1_im = b_im_q - p_im;
        end
        if (scale_q) begin
            o0_re = o0_re >>> 1;
            o0_im = o0_im >>> 1;
            o1_re = o1_re >>> 1;
            o1_im = o1_im >>> 1;
        end

        out_x0_d    = out_x0_q;
        out_x1_d    = out_x1_q;
        out_valid_d = out_valid_q;
        if (out_load) begin
            out_x0_d    = {o0_re, o0_im};
            out_x1_d    = {o1_re, o1_im};
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            w_re_q      <= '0;
            w_im_q      <= '0;
            mode_q      <= 1'b0;
            scale_q     <= 1'b0;
            pr_q        <= '0;
            pi_q        <= '0;
            out_x0_q    <= '0;
            out_x1_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            w_re_q      <= w_re_d;
            w_im_q      <= w_im_d;
            mode_q      <= mode_d;
            scale_q     <= scale_d;
            pr_q        <= pr_d;
            pi_q        <= pi_d;
            out_x0_q    <= out_x0_d;
            out_x1_q    <= out_x1_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_x0    = out_x0_q;
    assign out_x1    = out_x1_q;
    assign out_valid = out_valid_q;

endmodule
